// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the skid-buffered pipe stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // The encoding is {main_v, skid_v}, so valid flags are plain state bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } pipe_state_e;

    localparam logic [31:0] PC_RESET_VAL = 32'h0040_0000;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_skid_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; async active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Valid/ready pipeline register with a 2-entry skid buffer and
//               registered in_ready. Optional stall counter is compiled in
//               with PIPE_STAGE_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL   = '0,
    parameter int unsigned       STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    pipe_state_e      r_state;
    pipe_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_load_in;
    logic             w_main_load_skid;
    logic             w_skid_load;

    // Handshakes decoded from state flops only, so out_ready never reaches in_ready.
    assign w_in_fire  = in_valid  & ~r_state[0];
    assign w_out_fire = out_ready &  r_state[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: if (w_in_fire) w_state_nxt = ONE;
            ONE: begin
                if (w_in_fire && !w_out_fire) begin
                    w_state_nxt = FULL;
                end else if (!w_in_fire && w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL:  if (w_out_fire) w_state_nxt = ONE;
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
        end
    end

    always_comb begin
        out_valid        = r_state[1];
        in_ready         = ~r_state[0];
        w_main_load_in   = 1'b0;
        w_main_load_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (!flush) begin
            unique case (r_state)
                EMPTY: w_main_load_in = w_in_fire;
                ONE: begin
                    w_main_load_in = w_in_fire &  w_out_fire;
                    w_skid_load    = w_in_fire & ~w_out_fire;
                end
                FULL:  w_main_load_skid = w_out_fire;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data <= RESET_VAL;
            r_skid_data <= RESET_VAL;
        end else begin
            if (w_main_load_in) begin
                r_main_data <= in_data;
            end else if (w_main_load_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_skid_load) begin
                r_skid_data <= in_data;
            end
        end
    end

    assign out_data = r_main_data;

`ifdef PIPE_STAGE_STALL_CNT_EN
    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (out_valid & ~out_ready),
        .count (stall_cnt)
    );
`endif

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed vector bench for pipe_stage_skid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int unsigned c_width = 32;
    localparam int unsigned c_cnt_w = 3;

    typedef struct packed {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        er;
        logic [31:0] ed;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [c_width-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [c_width-1:0] out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [c_cnt_w-1:0] stall_cnt;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .WIDTH       (c_width),
        .RESET_VAL   (PC_RESET_VAL),
        .STALL_CNT_W (c_cnt_w)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic er, input logic [31:0] ed);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, "_in_ready"},  32'(in_ready),  32'(er));
        check({tag, "_out_data"},  out_data,       ed);
    endtask

    task automatic addv(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                        input logic ev, input logic er, input logic [31:0] ed);
        vec_t v;
        v = '{iv: iv, id: id, ordy: ordy, fl: fl, ev: ev, er: er, ed: ed};
        vq.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Columns: in_valid, in_data, out_ready, flush | out_valid, in_ready, out_data
        for (int i = 1; i <= 8; i++) addv(1, 32'(i), 1, 0, 1, 1, 32'(i));
        addv(0, 32'h0, 1, 0, 0, 1, 32'h8);
        addv(1, 32'hA, 0, 0, 1, 1, 32'hA);
        addv(1, 32'hB, 0, 0, 1, 0, 32'hA);
        addv(1, 32'hC, 0, 0, 1, 0, 32'hA);
        addv(1, 32'hC, 1, 0, 1, 1, 32'hB);
        addv(1, 32'hC, 1, 0, 1, 1, 32'hC);
        addv(0, 32'h0, 1, 0, 0, 1, 32'hC);
        addv(1, 32'h5, 0, 0, 1, 1, 32'h5);
        addv(1, 32'h6, 0, 0, 1, 0, 32'h5);
        addv(1, 32'hD, 0, 1, 0, 1, 32'h5);
        addv(0, 32'h0, 1, 0, 0, 1, 32'h5);
        addv(1, 32'h7, 1, 0, 1, 1, 32'h7);
        addv(1, 32'h9, 1, 1, 0, 1, 32'h7);
        addv(0, 32'h0, 1, 0, 0, 1, 32'h7);

        #1;
        check_outs("rst_held", 1'b0, 1'b1, PC_RESET_VAL);
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        #11 rst = 1'b0;
        @(posedge clk); #1;
        check_outs("rst_released", 1'b0, 1'b1, PC_RESET_VAL);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].iv, vq[i].id, vq[i].ordy, vq[i].fl);
            check_outs($sformatf("v%0d", i), vq[i].ev, vq[i].er, vq[i].ed);
        end

        // Async reset between edges while FULL drops both entries without a clock
        drive(1, 32'hE, 0, 0);
        drive(1, 32'hF, 0, 0);
        check_outs("pre_async_full", 1'b1, 1'b0, 32'hE);
        #2 rst = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 1'b1, PC_RESET_VAL);
        #2 rst = 1'b0;
        drive(0, 32'h0, 1, 0);
        check_outs("post_rst_empty", 1'b0, 1'b1, PC_RESET_VAL);
        drive(1, 32'h11, 1, 0);
        check_outs("post_rst_new", 1'b1, 1'b1, 32'h11);
        drive(0, 32'h0, 1, 0);
        check_outs("post_rst_drain", 1'b0, 1'b1, 32'h11);

`ifdef PIPE_STAGE_STALL_CNT_EN
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        check("cnt_cleared", 32'(stall_cnt), 32'd0);
        drive(1, 32'h22, 0, 0);
        check("cnt_after_push", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 0, 0);
        check("cnt_three", 32'(stall_cnt), 32'd3);
        for (int i = 0; i < 7; i++) drive(0, 32'h0, 0, 0);
        check("cnt_saturated", 32'(stall_cnt), 32'd7);
        drive(0, 32'h0, 0, 1);
        check("cnt_after_flush", 32'(stall_cnt), 32'd7);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("cnt_after_rst", 32'(stall_cnt), 32'd0);
        #2 rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_skid
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline register stage with a valid/ready handshake and a 2-entry skid buffer.
- Successor to the fixed 32-bit enable flops used between RISC-V Lite pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- in_ready is registered, which breaks the combinational ready path between stages.
- Adds flush (branch/jump squash) and a configurable data reset value, e.g. 32'h400000 for a PC stage.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VAL, '0, WIDTH-bit value loaded into both data registers on reset.
- STALL_CNT_W, 16, stall counter width; used only when the optional feature is compiled in.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream presents in_data
- in_ready  output  1  stage can accept; registered
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  payload, driven straight from the main register
- stall_cnt  output  STALL_CNT_W  present only with PIPE_STAGE_STALL_CNT_EN

Behaviour:
- Handshakes:
  - Input transfer happens when in_valid && in_ready at a rising edge.
  - Output transfer happens when out_valid && out_ready at a rising edge.
- Storage:
  - Main register: main_data, main_v. out_data = main_data, out_valid = main_v.
  - Skid register: skid_data, skid_v. in_ready = !skid_v.
- Reset (async, rst=1):
  - main_v = skid_v = 0.
  - main_data = skid_data = RESET_VAL.
  - Therefore out_valid = 0, in_ready = 1, out_data = RESET_VAL.
  - Asserting rst mid-transfer discards all entries immediately (no clock edge needed).
- States are encoded by {main_v, skid_v}: EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal.
- EMPTY:
  - input transfer -> ONE, main_data <= in_data.
- ONE:
  - input and output transfer -> ONE, main_data <= in_data.
  - input only -> FULL, skid_data <= in_data.
  - output only -> EMPTY.
  - neither -> hold.
- FULL (in_ready = 0, so no input transfer is possible):
  - output transfer -> ONE, main_data <= skid_data.
  - otherwise hold.
- Latency and throughput:
  - 1 cycle from input transfer to out_valid.
  - Sustained 1 transfer/cycle when out_ready stays high.
  - Data order is strictly FIFO.
- Flush:
  - At the edge, main_v <= 0 and skid_v <= 0.
  - An input transfer in the same cycle is discarded.
  - Flush has priority over every transition.
  - Data registers are not modified by flush.
- Data hold:
  - Data registers load only on the transitions above.
  - out_data holds its last value while out_valid = 0.
- No combinational path from out_ready to in_ready or to out_valid.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments at each rising edge where out_valid && !out_ready.
  - Saturates at 2^STALL_CNT_W - 1.
  - Cleared to 0 by rst only, not by flush.
- Not defined:
  - Port stall_cnt and its counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - typedef pipe_state_e {EMPTY, ONE, FULL}.
  - localparam PC_RESET_VAL = 32'h400000 for PC stages.
- Sub-module: optional sat_counter (WIDTH, enable, async rst) for the stall counter.
- All other logic is single-module.

Test Plan:
- Reset, then release with WIDTH=32, RESET_VAL=32'h400000 -> out_valid=0, in_ready=1, out_data=32'h400000.
- Stream 0x1..0x8 with in_valid=1, out_ready=1 every cycle -> out_data 0x1..0x8 on consecutive cycles, each one cycle after its input; in_ready stays 1.
- Stream 0xA, 0xB, 0xC with out_ready=0 -> 0xA in main, 0xB in skid, in_ready=0 after the 2nd transfer, 0xC held upstream. Then out_ready=1 -> output 0xA, 0xB, 0xC in order, nothing dropped or duplicated.
- FULL state; flush=1 together with in_valid=1 and in_data=0xD -> next cycle out_valid=0, in_ready=1, 0xD never appears at the output.
- Assert rst asynchronously between edges while FULL -> out_valid and in_ready change immediately to 0 and 1; out_data=RESET_VAL.
- With PIPE_STAGE_STALL_CNT_EN, STALL_CNT_W=3: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reads 7 and saturates; a flush leaves it at 7; rst clears it to 0.
